// File: rtl/sc_config_pkg.sv
// Shared constants and types for the scan-converter configuration register file.
package sc_config_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 16;

    localparam int unsigned CTRL_ADDR = 32'h000;
    localparam int unsigned IRQ_ADDR  = 32'h001;
    localparam int unsigned CNT_ADDR  = 32'h002;
    localparam int unsigned STAT_BASE = 32'h010;
    localparam int unsigned CFG_BASE  = 32'h040;

    typedef logic [31:0] cfg_word_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/sc_config_regfile.sv
// Double-buffered Avalon-MM config register file: CPU edits a working bank, which is
// copied atomically into the active bank on a frame boundary after commit, or immediately.
module sc_config_regfile
    import sc_config_pkg::*;
#(
    parameter int unsigned NUM_CFG  = 16,
    parameter int unsigned NUM_STAT = 2,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_W-1:0]            avalon_s_address,
    input  logic [31:0]                  avalon_s_writedata,
    input  logic [3:0]                   avalon_s_byteenable,
    input  logic                         avalon_s_write,
    input  logic                         avalon_s_read,
    input  logic                         avalon_s_chipselect,
    output logic [31:0]                  avalon_s_readdata,
    output logic                         avalon_s_waitrequest_n,
    input  logic                         frame_boundary_i,
    input  logic [NUM_STAT*DATA_W-1:0]   status_i,
    output logic [NUM_CFG*DATA_W-1:0]    cfg_active_o,
    output logic                         cfg_update_o,
    output logic                         irq_o
);

    localparam int unsigned BANK_W = NUM_CFG * DATA_W;

    rd_state_e          state_q, state_d;
    logic               pending_q, pending_d;
    logic               imm_q, imm_d;
    logic               done_q, done_d;
    logic               update_q, update_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cfg_word_t          readdata_q, readdata_d;

    logic               rd_start_c;
    logic               wr_ok_c;
    logic               wr_stall_c;
    logic               ctrl_wr_c;
    logic               commit_req_c;
    logic               irq_w1c_c;
    logic               transfer_c;
    cfg_word_t          rd_data_c;
    logic [BANK_W-1:0]  working_flat;

    // Bus strobes: reads start only from IDLE; writes are held off while a read is in RESP.
    assign rd_start_c   = avalon_s_chipselect && avalon_s_read && (state_q == RD_IDLE);
    assign wr_ok_c      = avalon_s_chipselect && avalon_s_write && !avalon_s_read
                          && (state_q == RD_IDLE);
    assign wr_stall_c   = avalon_s_chipselect && avalon_s_write && !avalon_s_read
                          && (state_q == RD_RESP);
    assign avalon_s_waitrequest_n = !(rd_start_c || wr_stall_c);

    assign ctrl_wr_c    = wr_ok_c && (avalon_s_address == ADDR_W'(CTRL_ADDR));
    assign commit_req_c = ctrl_wr_c && !avalon_s_writedata[1] && avalon_s_writedata[0];
    assign irq_w1c_c    = wr_ok_c && (avalon_s_address == ADDR_W'(IRQ_ADDR))
                          && avalon_s_writedata[0];
    assign transfer_c   = imm_q || (pending_q && frame_boundary_i);

    // Working/active banks as per-register flops so the whole bank copies in one cycle.
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        cfg_word_t work_d, work_q;
        cfg_word_t act_d, act_q;
        logic      hit_c;

        assign hit_c = wr_ok_c && (avalon_s_address == ADDR_W'(CFG_BASE + g));

        always_comb begin
            work_d = work_q;
            act_d  = act_q;
            for (int b = 0; b < 4; b++) begin
                if (hit_c && avalon_s_byteenable[b]) begin
                    work_d[b*8 +: 8] = avalon_s_writedata[b*8 +: 8];
                end
            end
            if (transfer_c) begin
                act_d = work_q;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                work_q <= '0;
                act_q  <= '0;
            end else begin
                work_q <= work_d;
                act_q  <= act_d;
            end
        end

        assign working_flat[g*DATA_W +: DATA_W] = work_q;
        assign cfg_active_o[g*DATA_W +: DATA_W] = act_q;
    end

    // Readback mux; mapped ranges are disjoint so at most one branch hits.
    always_comb begin
        rd_data_c = '0;
        if (avalon_s_address == ADDR_W'(CTRL_ADDR)) begin
            rd_data_c = {31'b0, pending_q};
        end
        if (avalon_s_address == ADDR_W'(IRQ_ADDR)) begin
            rd_data_c = {31'b0, done_q};
        end
        if (avalon_s_address == ADDR_W'(CNT_ADDR)) begin
            rd_data_c = {(DATA_W - CNT_W)'(0), cnt_q};
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (avalon_s_address == ADDR_W'(STAT_BASE + i)) begin
                rd_data_c = status_i[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (avalon_s_address == ADDR_W'(CFG_BASE + i)) begin
                rd_data_c = working_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for control, commit bookkeeping and the read FSM.
    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        imm_d      = ctrl_wr_c && avalon_s_writedata[1];
        pending_d  = pending_q && !transfer_c;
        done_d     = done_q;
        cnt_d      = cnt_q;
        update_d   = transfer_c;

        if (commit_req_c && !pending_q) begin
            pending_d = 1'b1;
        end

        if (transfer_c) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
        end else if (irq_w1c_c) begin
            done_d = 1'b0;
        end

        case (state_q)
            RD_IDLE: begin
                if (rd_start_c) begin
                    readdata_d = rd_data_c;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RD_IDLE;
            readdata_q <= '0;
            pending_q  <= 1'b0;
            imm_q      <= 1'b0;
            done_q     <= 1'b0;
            update_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
            pending_q  <= pending_d;
            imm_q      <= imm_d;
            done_q     <= done_d;
            update_q   <= update_d;
            cnt_q      <= cnt_d;
        end
    end

    assign avalon_s_readdata = readdata_q;
    assign cfg_update_o      = update_q;
    assign irq_o             = done_q;

endmodule

// File: tb/tb_sc_config_regfile.sv
// Randomized bench for sc_config_regfile against a cycle-level behavioural model.
module tb_sc_config_regfile;

    localparam int unsigned NUM_CFG  = 16;
    localparam int unsigned NUM_STAT = 2;
    localparam int unsigned ADDR_W   = 9;

    logic                        clk = 1'b0;
    logic                        rst_ni;
    logic [ADDR_W-1:0]           avalon_s_address;
    logic [31:0]                 avalon_s_writedata;
    logic [3:0]                  avalon_s_byteenable;
    logic                        avalon_s_write;
    logic                        avalon_s_read;
    logic                        avalon_s_chipselect;
    logic [31:0]                 avalon_s_readdata;
    logic                        avalon_s_waitrequest_n;
    logic                        frame_boundary_i;
    logic [NUM_STAT*32-1:0]      status_i;
    logic [NUM_CFG*32-1:0]       cfg_active_o;
    logic                        cfg_update_o;
    logic                        irq_o;

    always #5 clk = ~clk;

    sc_config_regfile #(
        .NUM_CFG  (NUM_CFG),
        .NUM_STAT (NUM_STAT),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .avalon_s_address       (avalon_s_address),
        .avalon_s_writedata     (avalon_s_writedata),
        .avalon_s_byteenable    (avalon_s_byteenable),
        .avalon_s_write         (avalon_s_write),
        .avalon_s_read          (avalon_s_read),
        .avalon_s_chipselect    (avalon_s_chipselect),
        .avalon_s_readdata      (avalon_s_readdata),
        .avalon_s_waitrequest_n (avalon_s_waitrequest_n),
        .frame_boundary_i       (frame_boundary_i),
        .status_i               (status_i),
        .cfg_active_o           (cfg_active_o),
        .cfg_update_o           (cfg_update_o),
        .irq_o                  (irq_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] work_m [NUM_CFG];
    logic [31:0] act_m  [NUM_CFG];
    bit          pend_m;
    bit          imm_m;
    bit          done_m;
    logic [15:0] cnt_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CFG; i++) begin
            work_m[i] = '0;
            act_m[i]  = '0;
        end
        pend_m = 0;
        imm_m  = 0;
        done_m = 0;
        cnt_m  = '0;
    endfunction

    function automatic logic [31:0] readback(input int a);
        if (a == 0) return {31'b0, pend_m};
        if (a == 1) return {31'b0, done_m};
        if (a == 2) return {16'b0, cnt_m};
        if (a >= 16 && a < 16 + NUM_STAT) return status_i[(a-16)*32 +: 32];
        if (a >= 64 && a < 64 + NUM_CFG) return work_m[a-64];
        return 32'h0;
    endfunction

    task automatic check_outputs(input bit exp_upd);
        check_val("cfg_update", 32'(cfg_update_o), 32'(exp_upd));
        check_val("irq", 32'(irq_o), 32'(done_m));
        for (int i = 0; i < NUM_CFG; i++) begin
            check_val($sformatf("active[%0d]", i), cfg_active_o[i*32 +: 32], act_m[i]);
        end
    endtask

    // One bus cycle: drive at posedge+1, check bus at negedge, advance model after posedge.
    task automatic tick(input bit wr, input bit rd, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit fb, input bit chk_wait, input bit exp_wait,
                        input bit chk_rd, input logic [31:0] exp_rd);
        logic [31:0] nwork [NUM_CFG];
        bit xfer;
        bit npend, ndone;
        int ai;
        avalon_s_chipselect = wr | rd;
        avalon_s_write      = wr;
        avalon_s_read       = rd;
        avalon_s_address    = a;
        avalon_s_writedata  = d;
        avalon_s_byteenable = be;
        frame_boundary_i    = fb;
        @(negedge clk);
        if (chk_wait) check_val("waitrequest_n", 32'(avalon_s_waitrequest_n), 32'(exp_wait));
        if (chk_rd)   check_val("readdata", avalon_s_readdata, exp_rd);
        ai    = int'(a);
        xfer  = imm_m || (pend_m && fb);
        nwork = work_m;
        npend = xfer ? 1'b0 : pend_m;
        ndone = xfer ? 1'b1 : done_m;
        if (wr) begin
            if (ai >= 64 && ai < 64 + NUM_CFG) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) nwork[ai-64][b*8 +: 8] = d[b*8 +: 8];
            end
            if (ai == 0 && !d[1] && d[0] && !pend_m) npend = 1'b1;
            if (ai == 1 && d[0] && !xfer) ndone = 1'b0;
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            act_m = work_m;
            cnt_m = cnt_m + 16'd1;
        end
        work_m = nwork;
        pend_m = npend;
        done_m = ndone;
        imm_m  = wr && (ai == 0) && d[1];
        check_outputs(xfer);
        avalon_s_chipselect = 0;
        avalon_s_write      = 0;
        avalon_s_read       = 0;
        frame_boundary_i    = 0;
    endtask

    task automatic bus_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input bit fb);
        tick(1, 0, a, d, be, fb, 1, 1, 0, 32'h0);
    endtask

    task automatic idle(input bit fb);
        tick(0, 0, 9'h000, 32'h0, 4'h0, fb, 1, 1, 0, 32'h0);
    endtask

    task automatic bus_read(input logic [8:0] a, input bit fb0, input bit fb1);
        logic [31:0] exp;
        for (int s = 0; s < NUM_STAT; s++) status_i[s*32 +: 32] = $urandom;
        exp = readback(int'(a));
        tick(0, 1, a, 32'h0, 4'h0, fb0, 1, 0, 0, 32'h0);
        tick(0, 1, a, 32'h0, 4'h0, fb1, 1, 1, 1, exp);
    endtask

    function automatic logic [8:0] rand_read_addr();
        case ($urandom_range(0, 7))
            0: return 9'h000;
            1: return 9'h001;
            2: return 9'h002;
            3: return 9'(16 + $urandom_range(0, NUM_STAT));
            4: return 9'h1FF;
            5: return 9'h003;
            default: return 9'(64 + $urandom_range(0, NUM_CFG + 2));
        endcase
    endfunction

    initial begin
        rst_ni              = 0;
        avalon_s_address    = '0;
        avalon_s_writedata  = '0;
        avalon_s_byteenable = '0;
        avalon_s_write      = 0;
        avalon_s_read       = 0;
        avalon_s_chipselect = 0;
        frame_boundary_i    = 0;
        status_i            = '0;
        model_reset();
        #12;
        check_val("rst_readdata", avalon_s_readdata, 32'h0);
        check_val("rst_waitreq_n", 32'(avalon_s_waitrequest_n), 32'h1);
        check_outputs(1'b0);
        #10 rst_ni = 1;
        @(posedge clk);
        #1;

        // Byte-enabled working write, readback, active untouched
        bus_write(9'h040, 32'hDEADBEEF, 4'b0101, 0);
        bus_read(9'h040, 0, 0);
        check_val("tp1_readback", avalon_s_readdata, 32'h00AD00EF);
        check_val("tp1_active0", cfg_active_o[31:0], 32'h0);

        // Frame-synchronised commit
        bus_write(9'h000, 32'h1, 4'hF, 0);
        idle(0);
        bus_read(9'h000, 0, 0);
        check_val("tp2_pending", avalon_s_readdata, 32'h1);
        idle(1);
        check_val("tp2_active0", cfg_active_o[31:0], 32'h00AD00EF);
        check_val("tp2_update", 32'(cfg_update_o), 32'h1);
        bus_read(9'h002, 0, 0);
        check_val("tp2_cnt", avalon_s_readdata, 32'h1);
        check_val("tp2_irq", 32'(irq_o), 32'h1);

        // Commit write coinciding with a boundary waits for the next one
        bus_write(9'h040, 32'h12345678, 4'hF, 0);
        bus_write(9'h000, 32'h1, 4'hF, 1);
        check_val("tp3_no_xfer", 32'(cfg_update_o), 32'h0);
        idle(0);
        idle(1);
        check_val("tp3_active0", cfg_active_o[31:0], 32'h12345678);
        idle(0);

        // Working write during the transfer cycle
        bus_write(9'h000, 32'h1, 4'hF, 0);
        bus_write(9'h041, 32'hCAFEF00D, 4'hF, 1);
        check_val("tp4_active1_old", cfg_active_o[63:32], 32'h0);
        bus_read(9'h041, 0, 0);
        check_val("tp4_working1", avalon_s_readdata, 32'hCAFEF00D);
        bus_write(9'h000, 32'h2, 4'hF, 0);
        idle(0);
        check_val("tp4_active1_new", cfg_active_o[63:32], 32'hCAFEF00D);

        // W1C losing to a simultaneous set, then clearing
        bus_write(9'h000, 32'h1, 4'hF, 0);
        bus_write(9'h001, 32'h1, 4'hF, 1);
        check_val("tp5_irq_kept", 32'(irq_o), 32'h1);
        bus_write(9'h001, 32'h1, 4'hF, 0);
        check_val("tp5_irq_clr", 32'(irq_o), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            bit fb;
            int op;
            fb = ($urandom_range(0, 4) == 0);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: bus_write(9'(64 + $urandom_range(0, NUM_CFG + 3)), $urandom,
                                   4'($urandom_range(0, 15)), fb);
                3: bus_write(9'h000, ($urandom_range(0, 5) == 0) ? 32'h2 : 32'($urandom_range(0, 1)), 4'hF, fb);
                4: bus_write(9'h001, 32'($urandom_range(0, 1)), 4'hF, fb);
                5: bus_write(($urandom_range(0, 1) == 1) ? 9'h010 : 9'h1FF, $urandom, 4'hF, fb);
                6, 7: bus_read(rand_read_addr(), fb, ($urandom_range(0, 4) == 0));
                default: idle(fb);
            endcase
        end

        // Reset in the middle of a read response with a commit pending
        bus_write(9'h000, 32'h1, 4'hF, 0);
        tick(0, 1, 9'h000, 32'h0, 4'h0, 0, 1, 0, 0, 32'h0);
        #2;
        rst_ni              = 0;
        avalon_s_chipselect = 0;
        avalon_s_read       = 0;
        #1;
        model_reset();
        check_val("rst2_readdata", avalon_s_readdata, 32'h0);
        check_val("rst2_waitreq_n", 32'(avalon_s_waitrequest_n), 32'h1);
        check_outputs(1'b0);
        #10 rst_ni = 1;
        @(posedge clk);
        #1;
        bus_read(9'h000, 0, 0);
        check_val("rst2_ctrl", avalon_s_readdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
